// File: rtl/rr_bus_arbiter_if.sv
// Requester-side streams and shared channel of the round-robin bus arbiter.
// The arbiter takes the slave modport; the requester/consumer side takes master.
interface rr_bus_arbiter_if #(
  parameter int NR_REQ   = 8,
  parameter int DATA_LEN = 64,
  parameter int ID_LEN   = 3,
  parameter int CNT_LEN  = 8
);
  logic [NR_REQ-1:0]          req_valid;
  logic [NR_REQ-1:0]          req_last;
  logic [NR_REQ*DATA_LEN-1:0] req_data;
  logic [NR_REQ-1:0]          req_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_LEN-1:0]        out_data;
  logic                       out_last;
  logic [ID_LEN-1:0]          out_id;
  logic                       busy;
  logic [CNT_LEN-1:0]         beat_cnt;

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_id,
    output busy,
    output beat_cnt
  );

  modport master (
    output req_valid,
    output req_last,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_id,
    input  busy,
    input  beat_cnt
  );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Burst-granular round-robin arbiter: NR_REQ valid/ready streams onto
// one channel, grant held until the beat carrying last is accepted.
module rr_bus_arbiter #(
  parameter int NR_REQ   = 8,
  parameter int DATA_LEN = 64,
  parameter int ID_LEN   = 3,
  parameter int CNT_LEN  = 8
) (
  input logic            clk,
  input logic            rst_n,
  rr_bus_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ID_LEN-1:0]   grant_q;
  logic [ID_LEN-1:0]   grant_d;
  logic [ID_LEN-1:0]   ptr_q;
  logic [ID_LEN-1:0]   ptr_d;
  logic [CNT_LEN-1:0]  cnt_q;
  logic [CNT_LEN-1:0]  cnt_d;
  logic [ID_LEN-1:0]   pick;
  logic [ID_LEN-1:0]   idx;
  logic                found;
  logic                xfer;
  logic                burst_end;
  logic [DATA_LEN-1:0] lane [NR_REQ];

  for (genvar n = 0; n < NR_REQ; n++) begin : g_lane
    assign lane[n] = bus.req_data[DATA_LEN*n +: DATA_LEN];
  end

  // ID_LEN-bit index wraps modulo NR_REQ, so the scan starts at ptr.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx = ptr_q + ID_LEN'(i);
      if (!found && bus.req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign xfer = (state_q == BUSY)
              & bus.req_valid[grant_q]
              & bus.out_ready;

  assign burst_end = xfer & bus.req_last[grant_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (xfer && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_LEN'(1);
        end
        if (burst_end) begin
          state_d = IDLE;
          ptr_d   = grant_q + ID_LEN'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel mux is keyed off the registered grant only; zero while idle.
  always_comb begin
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.out_id    = '0;
    bus.busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
      end
      BUSY: begin
        bus.busy               = 1'b1;
        bus.out_id             = grant_q;
        bus.out_valid          = bus.req_valid[grant_q];
        bus.out_data           = lane[grant_q];
        bus.out_last           = bus.req_last[grant_q];
        bus.req_ready[grant_q] = bus.out_ready;
      end
      default: bus.busy = 1'b0;
    endcase
  end

  assign bus.beat_cnt = cnt_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: per-requester beat queues drive
// the streams, a monitor checks accepted beats against a scoreboard.
module tb_rr_bus_arbiter;
  localparam int NR = 8;
  localparam int DW = 64;

  typedef struct packed {
    logic [2:0]  id;
    logic [63:0] data;
    logic        last;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  rr_bus_arbiter_if bus ();

  rr_bus_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb [$];
  int          stamps [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [64:0] bm [NR][8];
  int          wr [NR] = '{default: 0};
  int          rd [NR] = '{default: 0};
  int          skip [NR] = '{default: 0};
  logic [NR-1:0] hold = '0;
  logic [NR-1:0] acc;
  exp_t        e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] dat(int r, int b);
    return {32'hD0D0_0000 | 32'(r), 32'h0000_1000 | 32'(b)};
  endfunction

  task automatic give(int r, logic [63:0] d, logic last);
    bm[r][wr[r]] = {last, d};
    wr[r]++;
  endtask

  task automatic want(int r, logic [63:0] d, logic last, int cnt);
    exp_t x;
    x.id   = 3'(r);
    x.data = d;
    x.last = last;
    x.cnt  = 8'(cnt);
    sb.push_back(x);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_sb(string name, int keep, int limit);
    int i;
    i = 0;
    while (sb.size() > keep && i < limit) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (sb.size() > keep) begin
      total++;
      bad++;
      $display("FAIL %s timeout: pending %0d want %0d",
               name, sb.size(), keep);
      sb.delete();
    end
  endtask

  task automatic wait_done(string name, int limit);
    wait_sb(name, 0, limit);
    @(negedge clk);
  endtask

  // Requester model: present queue head, advance on acceptance.
  initial begin
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #3;
      if (!rst_n) acc = '0;
      v = '0;
      l = '0;
      d = '0;
      for (int n = 0; n < NR; n++) begin
        if (acc[n]) rd[n]++;
        if (rd[n] < skip[n]) rd[n] = skip[n];
        if (rd[n] < wr[n] && !hold[n]) begin
          v[n]            = 1'b1;
          l[n]            = bm[n][rd[n]][64];
          d[n*DW +: DW]   = bm[n][rd[n]][63:0];
        end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL beat unexpected: id %0d data %0h",
                   bus.out_id, bus.out_data);
        end else begin
          e = sb.pop_front();
          stamps.push_back(cyc);
          if (bus.out_id !== e.id || bus.out_data !== e.data ||
              bus.out_last !== e.last || bus.beat_cnt !== e.cnt ||
              bus.req_ready !== (8'b1 << e.id)) begin
            bad++;
            $display("FAIL beat: got id %0d data %0h last %0b cnt %0d rdy %0h want id %0d data %0h last %0b cnt %0d",
                     bus.out_id, bus.out_data, bus.out_last,
                     bus.beat_cnt, bus.req_ready,
                     e.id, e.data, e.last, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    int c0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #5;
    chk("rst busy", 64'(bus.busy), 0);
    chk("rst out_valid", 64'(bus.out_valid), 0);
    chk("rst req_ready", 64'(bus.req_ready), 0);
    chk("rst out_id", 64'(bus.out_id), 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst beat_cnt", 64'(bus.beat_cnt), 0);
    step();
    rst_n = 1'b1;

    // single beat from requester 0
    step();
    c0 = cyc;
    stamps.delete();
    give(0, 64'hA5, 1'b1);
    want(0, 64'hA5, 1'b1, 0);
    wait_done("t1", 10);
    chk("t1 grant cycle", 64'(stamps.size() > 0 ? stamps[0] : -1),
        64'(c0 + 1));
    chk("t1 busy after", 64'(bus.busy), 0);
    chk("t1 beat_cnt", 64'(bus.beat_cnt), 1);
    chk("t1 out_valid idle", 64'(bus.out_valid), 0);

    // ptr now 1: all request, requester 0 has two beats
    step();
    stamps.delete();
    for (int r = 0; r < NR; r++) give(r, dat(r, 0), 1'b1);
    give(0, dat(0, 1), 1'b1);
    for (int r = 1; r < NR; r++) want(r, dat(r, 0), 1'b1, 0);
    want(0, dat(0, 0), 1'b1, 0);
    want(0, dat(0, 1), 1'b1, 0);
    wait_done("t2", 60);
    chk("t2 count", 64'(stamps.size()), 9);
    chk("t2 spacing", 64'(stamps.size() == 9 ? stamps[8] - stamps[0] : -1),
        16);

    // ptr 1: 4-beat burst on 3 while 5 waits
    step();
    stamps.delete();
    for (int b = 0; b < 4; b++) give(3, dat(3, b), b == 3);
    give(5, dat(5, 0), 1'b1);
    for (int b = 0; b < 4; b++) want(3, dat(3, b), b == 3, b);
    want(5, dat(5, 0), 1'b1, 0);
    wait_done("t3", 30);
    chk("t3 burst span", 64'(stamps.size() == 5 ? stamps[3] - stamps[0] : -1),
        3);
    chk("t3 bubble", 64'(stamps.size() == 5 ? stamps[4] - stamps[3] : -1),
        2);
    chk("t3 beat_cnt", 64'(bus.beat_cnt), 1);

    // ptr 6: requester 2 with out_ready toggling
    step();
    stamps.delete();
    for (int b = 0; b < 4; b++) give(2, dat(2, b), b == 3);
    for (int b = 0; b < 4; b++) want(2, dat(2, b), b == 3, b);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      step();
      bus.out_ready = ~bus.out_ready;
    end
    bus.out_ready = 1'b1;
    wait_done("t4", 10);
    for (int i = 0; i < 3; i++)
      chk("t4 gap", 64'(stamps.size() == 4 ? stamps[i+1] - stamps[i] : -1),
          2);
    chk("t4 beat_cnt", 64'(bus.beat_cnt), 4);

    // ptr 3: requester 6 stalls mid-burst, 1 waits
    step();
    stamps.delete();
    for (int b = 0; b < 3; b++) give(6, dat(6, b), b == 2);
    give(1, dat(1, 0), 1'b1);
    for (int b = 0; b < 3; b++) want(6, dat(6, b), b == 2, b);
    want(1, dat(1, 0), 1'b1, 0);
    wait_sb("t5 first", 3, 20);
    step();
    hold[6] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5 stall out_valid", 64'(bus.out_valid), 0);
      chk("t5 stall out_id", 64'(bus.out_id), 6);
      chk("t5 stall ready1", 64'(bus.req_ready[1]), 0);
    end
    step();
    hold[6] = 1'b0;
    wait_done("t5", 30);
    chk("t5 resume gap", 64'(stamps.size() == 4 ? stamps[1] - stamps[0] : -1),
        4);
    chk("t5 beat_cnt", 64'(bus.beat_cnt), 1);

    // ptr 2: reset mid-burst of requester 4
    step();
    stamps.delete();
    for (int b = 0; b < 4; b++) give(4, dat(4, b), b == 3);
    want(4, dat(4, 0), 1'b0, 0);
    want(4, dat(4, 1), 1'b0, 1);
    wait_sb("t6 beats", 0, 20);
    step();
    chk("t6 pre beat_cnt", 64'(bus.beat_cnt), 2);
    chk("t6 pre out_id", 64'(bus.out_id), 4);
    #2;
    rst_n = 1'b0;
    skip[4] = wr[4];
    #1;
    chk("t6 async busy", 64'(bus.busy), 0);
    chk("t6 async out_valid", 64'(bus.out_valid), 0);
    chk("t6 async req_ready", 64'(bus.req_ready), 0);
    chk("t6 async out_data", bus.out_data, 0);
    chk("t6 async beat_cnt", 64'(bus.beat_cnt), 0);
    step();
    step();
    stamps.delete();
    give(7, dat(7, 0), 1'b1);
    give(0, dat(0, 2), 1'b1);
    want(0, dat(0, 2), 1'b1, 0);
    want(7, dat(7, 0), 1'b1, 0);
    step();
    rst_n = 1'b1;
    wait_done("t6 after", 20);
    chk("t6 count", 64'(stamps.size()), 2);
    chk("t6 busy end", 64'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one 64-bit transfer channel among 8 requesters.
- Each requester presents a valid/ready stream of beats. A burst ends with the beat that carries `last`.
- The arbiter holds a grant for a whole burst, then rotates priority.
- It drives the channel's N:1 data select (`MuxKey`-style lane select keyed by grant id). It sits between LSU/IFU-side masters and the shared memory/bus port of the NPC.

Parameters:
- NR_REQ, 8, number of requesters (power of two, 2..16).
- DATA_LEN, 64, beat data width.
- ID_LEN, 3, grant id width, equals log2(NR_REQ).
- CNT_LEN, 8, width of the burst beat counter.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NR_REQ, bit n: requester n has a beat.
- req_last, input, NR_REQ, bit n: requester n's current beat ends its burst.
- req_data, input, NR_REQ*DATA_LEN, lane n at [DATA_LEN*(n+1)-1 : DATA_LEN*n].
- req_ready, output, NR_REQ, bit n: beat n accepted this cycle.
- out_valid, output, 1, granted requester's beat is valid.
- out_ready, input, 1, downstream accepts the beat.
- out_data, output, DATA_LEN, data of granted lane.
- out_last, output, 1, last flag of granted lane.
- out_id, output, ID_LEN, current grant id.
- busy, output, 1, a grant is held (state BUSY).
- beat_cnt, output, CNT_LEN, beats accepted in the current burst; saturates at all-ones.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, grant=0, ptr=0, beat_cnt=0. All outputs low or zero: req_ready=0, out_valid=0, out_data=0, out_last=0, out_id=0, busy=0.
- State IDLE:
  - busy=0, out_valid=0, req_ready=0.
  - If any req_valid bit is set: select the first set bit scanning ptr, ptr+1, … modulo NR_REQ. Register it as grant and go to BUSY next cycle, with beat_cnt cleared to 0.
  - If no request, stay in IDLE.
- State BUSY:
  - busy=1, out_id=grant.
  - out_valid=req_valid[grant]. out_data=lane[grant]. out_last=req_last[grant]. These are combinational from the registered grant.
  - req_ready[grant]=out_ready; all other req_ready bits are 0.
- Handshake: a beat transfers when out_valid & out_ready.
  - On each transfer, beat_cnt increments by 1, saturating at 2^CNT_LEN-1.
- Burst end: on a transfer with out_last=1:
  - Next state is IDLE.
  - ptr = grant+1 (wraps from NR_REQ-1 to 0).
  - beat_cnt holds its final value while in IDLE; it clears on the next grant.
- Latency:
  - Request in IDLE at cycle t gives a grant visible at t+1. A single-beat burst with out_ready=1 completes at t+1.
  - There is one IDLE bubble cycle between consecutive bursts. Minimum 2 cycles per single-beat burst.
- No preemption:
  - If req_valid[grant] drops mid-burst, the grant is held, out_valid=0, and the arbiter waits indefinitely.
  - Requests from other requesters are ignored while BUSY.
- req_valid is not sampled as a grant request in BUSY. Any requester may change its inputs freely when not granted.
- Rules requesters must follow:
  - While granted, req_data and req_last are held stable while req_valid=1 and req_ready=0.
  - The arbiter does not check this.
- Simultaneous requests: the requester nearest at or after ptr wins. With ptr=0 and all requesting, the order is 0,1,…,7,0.
- out_ready asserted with out_valid=0: no transfer, no count.
- Reset mid-burst: the burst is abandoned immediately and ptr returns to 0. No completion is signalled.

Test Plan:
- Reset, then req_valid=8'h01 with last=1, data lane0=64'hA5: cycle+1 shows out_valid=1, out_id=0, out_data=64'hA5, req_ready=8'h01. Next cycle busy=0 and ptr=1.
- All 8 requesting single beats continuously, out_ready=1: out_id sequence 0,1,2,3,4,5,6,7,0, one grant every 2 cycles.
- Requester 3 sends a 4-beat burst (last on beat 4) while requester 5 requests: out_id stays 3 for 4 transfers and beat_cnt reaches 4. Requester 5 is granted in the cycle after IDLE.
- Granted requester 2 with out_ready toggling 1,0,1,0: transfers occur only on out_ready=1 cycles, data remains stable, beat_cnt increments only then.
- Granted requester 6 drops valid for 3 cycles mid-burst while requester 1 requests: out_valid=0, out_id=6, req_ready[1]=0 throughout. The burst then resumes and completes on last.
- Assert rst_n=0 asynchronously mid-burst with beat_cnt=2: outputs go to zero without waiting for a clock edge. After release with requesters 7 and 0 requesting, requester 0 is granted first (ptr=0).
